// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size and FSM encodings for the load/store unit
//
// Purpose : func3-compatible access size codes, FSM state codes and the
//           request legality check shared by mem_stage_lsu and lsu_align.
// Ports   : none (package).
package lsu_pkg;

  typedef logic [2:0] lsu_size_t;
  typedef logic [1:0] lsu_state_t;

  // Access sizes, identical to the RISC-V load/store func3 field.
  localparam lsu_size_t SZ_B  = 3'b000;
  localparam lsu_size_t SZ_H  = 3'b001;
  localparam lsu_size_t SZ_W  = 3'b010;
  localparam lsu_size_t SZ_BU = 3'b100;
  localparam lsu_size_t SZ_HU = 3'b101;

  // Width part of the size code (func3[1:0]); used for store steering.
  localparam logic [1:0] WD_BYTE = 2'b00;
  localparam logic [1:0] WD_HALF = 2'b01;

  // FSM states.
  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_REQ  = 2'd1;
  localparam lsu_state_t ST_RESP = 2'd2;

  // True for an illegal size code or an access not aligned to its width.
  function automatic logic req_is_error(input lsu_size_t size, input logic [1:0] off);
    logic err;
    case (size)
      SZ_B, SZ_BU: err = 1'b0;
      SZ_H, SZ_HU: err = off[0];
      SZ_W:        err = (off != 2'b00);
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering and load lane extraction
//
// Purpose : purely combinational data alignment for the LSU.
// Ports   : st_size/st_off/st_wdata -> st_be/st_data   store steering
//           ld_size/ld_off/ld_raw   -> ld_data         load extract + extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  lsu_size_t   ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  // Store data is replicated across lanes so the byte enables alone pick
  // the destination bytes; no shifting of the data is needed.
  always_comb begin
    st_be   = 4'b1111;
    st_data = st_wdata;
    case (st_size)
      WD_BYTE: begin
        st_be   = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      WD_HALF: begin
        st_be   = 4'b0011 << st_off;
        st_data = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
    endcase
  end

  always_comb begin
    lane    = ld_raw >> {ld_off, 3'b000};
    ld_data = ld_raw;
    case (ld_size)
      SZ_B:    ld_data = {{24{lane[7]}}, lane[7:0]};
      SZ_H:    ld_data = {{16{lane[15]}}, lane[15:0]};
      SZ_BU:   ld_data = {24'h000000, lane[7:0]};
      SZ_HU:   ld_data = {16'h0000, lane[15:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with a 3-state FSM
//
// Purpose : accepts one load/store from execute, issues a word-aligned
//           memory request, returns aligned/extended load data.
// Ports   : req_*      execute-side request (valid/ready handshake)
//           mem_req_*, mem_addr, mem_be, mem_wdata   memory request
//           mem_resp_* memory load response
//           ld_valid/ld_data  load result pulse
//           misalign_err      rejected-request pulse
//           stall             high while a transaction is in flight
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              misalign_err,
  output logic              stall
);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  lsu_size_t         size_q;

  logic              accept;
  logic              req_err;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [31:0]       ld_ext;

  assign req_ready     = (state == ST_IDLE);
  assign stall         = (state != ST_IDLE);
  assign mem_req_valid = (state == ST_REQ);
  assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign accept        = req_valid && req_ready;
  assign req_err       = req_is_error(req_size, req_addr[1:0]);

  // Store steering works on the live request (captured at accept); load
  // extraction works on the registered address/size.
  lsu_align u_align (
    .st_size  (req_size[1:0]),
    .st_off   (req_addr[1:0]),
    .st_wdata (req_wdata),
    .st_be    (st_be),
    .st_data  (st_data),
    .ld_size  (size_q),
    .ld_off   (addr_q[1:0]),
    .ld_raw   (mem_resp_data),
    .ld_data  (ld_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      mem_be       <= 4'b0000;
      mem_wdata    <= '0;
      ld_data      <= '0;
      ld_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      ld_valid     <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            we_q   <= req_we;
            size_q <= req_size;
            if (req_err) begin
              misalign_err <= 1'b1;
            end else begin
              state     <= ST_REQ;
              mem_be    <= req_we ? st_be : 4'b0000;
              mem_wdata <= req_we ? st_data : '0;
            end
          end
        end
        ST_REQ: begin
          // Responses arriving here (even in the handshake cycle) are ignored.
          if (mem_req_ready) begin
            state <= we_q ? ST_IDLE : ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_resp_valid) begin
            ld_data  <= ld_ext;
            ld_valid <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misalign_err;
  logic        stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .misalign_err   (misalign_err),
    .stall          (stall)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk1("excl_ld_err", ld_valid & misalign_err, 1'b0);
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_err(input logic [2:0] size, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (size == 3 || size >= 6) return 1'b1;
    if ((size == 1 || size == 5) && (off % 2) != 0) return 1'b1;
    if (size == 2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (size == 0) return 4'(1 << off);
    if (size == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] w);
    if (size == 0) return (w % 256) * 32'h01010101;
    if (size == 1) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] raw);
    logic [31:0] sh;
    logic [31:0] v;
    sh = raw / (32'd1 << (8 * (addr % 4)));
    case (size)
      3'd0: begin v = sh % 256;   if (v > 127)   v = v + 32'hFFFFFF00; end
      3'd1: begin v = sh % 65536; if (v > 32767) v = v + 32'hFFFF0000; end
      3'd4: v = sh % 256;
      3'd5: v = sh % 65536;
      default: v = raw;
    endcase
    return v;
  endfunction

  // One complete transaction with per-cycle checks.
  task automatic txn(input string nm, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] raw, input int req_dly, input int resp_dly);
    logic err;
    err = m_err(size, addr);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    chk1({nm, ".req_ready"}, req_ready, 1'b1);
    step();
    // Scramble the request bus to prove the DUT uses its registered copy.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (err) begin
      chk1({nm, ".misalign_err"}, misalign_err, 1'b1);
      chk1({nm, ".err_no_mreq"}, mem_req_valid, 1'b0);
      chk1({nm, ".err_ready"}, req_ready, 1'b1);
      chk1({nm, ".err_stall"}, stall, 1'b0);
      step();
      chk1({nm, ".err_pulse_end"}, misalign_err, 1'b0);
      chk1({nm, ".err_no_mreq2"}, mem_req_valid, 1'b0);
      return;
    end
    chk1({nm, ".no_err"}, misalign_err, 1'b0);
    for (int c = 0; c <= req_dly; c++) begin
      chk1({nm, ".mem_req_valid"}, mem_req_valid, 1'b1);
      chk1({nm, ".stall_req"}, stall, 1'b1);
      chk1({nm, ".ready_low"}, req_ready, 1'b0);
      chk32({nm, ".mem_addr"}, mem_addr, addr & 32'hFFFFFFFC);
      chk32({nm, ".mem_be"}, {28'h0, mem_be}, {28'h0, (we ? m_be(size, addr) : 4'h0)});
      if (we) chk32({nm, ".mem_wdata"}, mem_wdata, m_wdata(size, wdata));
      mem_req_ready  = (c == req_dly);
      mem_resp_valid = 1'b1;          // must be ignored while in REQ
      mem_resp_data  = ~raw;
      step();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    if (we) begin
      chk1({nm, ".st_idle"}, stall, 1'b0);
      chk1({nm, ".st_ready"}, req_ready, 1'b1);
      chk1({nm, ".st_mreq_drop"}, mem_req_valid, 1'b0);
      chk1({nm, ".st_no_ld"}, ld_valid, 1'b0);
      step();
      chk1({nm, ".st_no_ld2"}, ld_valid, 1'b0);
      return;
    end
    for (int c = 0; c <= resp_dly; c++) begin
      chk1({nm, ".resp_wait_ld"}, ld_valid, 1'b0);
      chk1({nm, ".resp_stall"}, stall, 1'b1);
      chk1({nm, ".resp_no_mreq"}, mem_req_valid, 1'b0);
      mem_resp_valid = (c == resp_dly);
      mem_resp_data  = (c == resp_dly) ? raw : ~raw;
      step();
    end
    mem_resp_valid = 1'b0;
    chk1({nm, ".ld_valid"}, ld_valid, 1'b1);
    chk32({nm, ".ld_data"}, ld_data, m_load(size, addr, raw));
    chk1({nm, ".ld_idle"}, stall, 1'b0);
    chk1({nm, ".ld_ready"}, req_ready, 1'b1);
    step();
    chk1({nm, ".ld_pulse_end"}, ld_valid, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk1({nm, ".req_ready"}, req_ready, 1'b1);
    chk1({nm, ".stall"}, stall, 1'b0);
    chk1({nm, ".mem_req_valid"}, mem_req_valid, 1'b0);
    chk1({nm, ".ld_valid"}, ld_valid, 1'b0);
    chk1({nm, ".misalign_err"}, misalign_err, 1'b0);
    chk32({nm, ".ld_data"}, ld_data, 32'h0);
    chk32({nm, ".mem_be"}, {28'h0, mem_be}, 32'h0);
    chk32({nm, ".mem_wdata"}, mem_wdata, 32'h0);
  endtask

  logic [2:0] st_sizes [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    // Reset state
    #2;
    chk_reset_outputs("por");
    step();
    step();
    reset = 1'b0;
    step();
    chk_reset_outputs("post_rel");

    // Directed cases
    txn("sb_1003", 1'b1, 3'd0, 32'h00001003, 32'h000000A5, 32'h0, 0, 0);
    chk32("sb_1003.model_be", {28'h0, m_be(3'd0, 32'h1003)}, 32'h8);
    txn("lb_2002",  1'b0, 3'd0, 32'h00002002, 32'h0, 32'h12F45678, 0, 0);
    chk32("lb_2002.ref", m_load(3'd0, 32'h2002, 32'h12F45678), 32'hFFFFFFF4);
    txn("lbu_2002", 1'b0, 3'd4, 32'h00002002, 32'h0, 32'h12F45678, 0, 1);
    txn("lh_2002",  1'b0, 3'd1, 32'h00002002, 32'h0, 32'h12F45678, 1, 0);
    txn("lhu_2002", 1'b0, 3'd5, 32'h00002002, 32'h0, 32'h80F4F678, 0, 0);
    txn("lw_3001",  1'b0, 3'd2, 32'h00003001, 32'h0, 32'h0, 0, 0);
    txn("sz011",    1'b0, 3'd3, 32'h00003000, 32'h0, 32'h0, 0, 0);
    txn("sw_stall", 1'b1, 3'd2, 32'h00004008, 32'hCAFEF00D, 32'h0, 3, 0);
    txn("sh_2",     1'b1, 3'd1, 32'h00004002, 32'h1234BEEF, 32'h0, 0, 0);
    txn("lw_ok",    1'b0, 3'd2, 32'h00005000, 32'h0, 32'h89ABCDEF, 2, 2);

    // Reset while in RESP; a late response must not yield ld_valid.
    req_valid = 1'b1; req_we = 1'b0; req_size = 3'd2; req_addr = 32'h00006000;
    step();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk1("rst_resp.in_resp", stall, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_resp.imm");
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("rst_resp.no_late_ld", ld_valid, 1'b0);
      chk1("rst_resp.idle", stall, 1'b0);
    end
    mem_resp_valid = 1'b0;
    step();

    // Reset while a store sits in REQ clears steered store outputs.
    req_valid = 1'b1; req_we = 1'b1; req_size = 3'd0; req_addr = 32'h00007001;
    req_wdata = 32'h0000005A;
    step();
    req_valid = 1'b0;
    chk32("rst_req.be_set", {28'h0, mem_be}, 32'h2);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_req.imm");
    step();
    reset = 1'b0;
    step();

    // Randomized transactions against the model
    for (int n = 0; n < 80; n++) begin
      logic        we;
      logic [2:0]  sz;
      logic [31:0] a;
      we = 1'($urandom);
      sz = we ? st_sizes[$urandom_range(0, 5)] : 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
      txn("rnd", we, sz, a, $urandom, $urandom,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have a parameter ADDR_W, default 32, giving the byte-address width.
REQ-002 The block SHALL have a parameter DATA_W, default 32, giving the data width; only 32 is supported.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req_valid  in  1  execute stage presents a load/store.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_size  in  3  func3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 mem_req_valid  out  1  request to data memory.
REQ-012 mem_req_ready  in  1  memory accepts the request.
REQ-013 mem_addr  out  ADDR_W  word-aligned address, low 2 bits 0.
REQ-014 mem_be  out  4  byte write enables, all 0 for loads.
REQ-015 mem_wdata  out  32  lane-replicated store data.
REQ-016 mem_resp_valid  in  1  load data valid.
REQ-017 mem_resp_data  in  32  raw word from memory.
REQ-018 ld_valid  out  1  one-cycle pulse: ld_data is valid.
REQ-019 ld_data  out  32  aligned, extended load result.
REQ-020 misalign_err  out  1  one-cycle pulse: request rejected as misaligned or illegal size.
REQ-021 stall  out  1  pipeline hold; high whenever state is not IDLE.

Function
REQ-022 FSM states SHALL be IDLE, REQ and RESP. req_ready SHALL be 1 only in IDLE.
REQ-023 Accept occurs when req_valid and req_ready are both 1. On accept, addr, we, size and wdata SHALL be registered.
REQ-024 Illegal sizes (011, 110, 111) and misaligned requests SHALL be treated as errors: H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-025 An error request SHALL pulse misalign_err in the cycle after accept, issue no memory request, and leave the FSM in IDLE.
REQ-026 A legal accept SHALL move the FSM to REQ. mem_req_valid SHALL be 1 from the next cycle, held with stable outputs until mem_req_ready=1.
REQ-027 Stores SHALL produce these byte enables and data:
  - SB: mem_be = 0001<<addr[1:0]; mem_wdata = four copies of wdata[7:0].
  - SH: mem_be = 0011<<addr[1:0]; mem_wdata = two copies of wdata[15:0].
  - SW: mem_be = 1111; mem_wdata = wdata.
REQ-028 A store handshake (REQ with mem_req_ready=1) SHALL return the FSM to IDLE the next cycle. No ld_valid SHALL be produced.
REQ-029 A load handshake SHALL move the FSM to RESP. mem_be SHALL be 0000 for loads.
REQ-030 In RESP, mem_resp_valid=1 SHALL register the selected lane into ld_data, pulse ld_valid for one cycle, and return the FSM to IDLE, all in the next cycle.
  - Lane selection: mem_resp_data >> (8*addr[1:0]).
  - B/H SHALL sign-extend; BU/HU SHALL zero-extend.
REQ-031 mem_resp_valid SHALL be ignored in IDLE and REQ, including in the handshake cycle. Minimum load latency is accept + 3 cycles with a zero-wait memory.
REQ-032 Back-to-back operation: a new request MAY be accepted in the cycle the FSM returns to IDLE. ld_valid and misalign_err SHALL never be high together.
REQ-033 mem_addr SHALL be {addr[ADDR_W-1:2], 2'b00}.

Reset
REQ-034 While reset=1, the block SHALL immediately set:
  - state to IDLE;
  - mem_req_valid, ld_valid and misalign_err to 0;
  - ld_data, mem_be and mem_wdata to 0;
  - stall to 0 and req_ready to 1.
REQ-035 Reset mid-operation SHALL abandon the transaction. No late ld_valid SHALL be produced for it.

Structure
REQ-036 The size encodings (matching func3) and the FSM state encodings SHALL live in a shared header/package, lsu_pkg.
REQ-037 Store lane steering and load extraction SHALL be one combinational sub-module, lsu_align. The FSM and registers SHALL remain in mem_stage_lsu.

Verification
REQ-038 SB, addr 0x1003, wdata 0x000000A5, mem_req_ready=1 immediately -> mem_be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x1000, IDLE 2 cycles after accept.
REQ-039 LB, addr 0x2002, response 0x12F45678 -> ld_data 0xFFFFFFF4; LBU same -> 0x000000F4; LH, addr 0x2002 -> 0x000012F4.
REQ-040 LW, addr 0x3001 -> misalign_err pulse, no mem_req_valid, req_ready stays 1; size 011 -> misalign_err.
REQ-041 SW with mem_req_ready low for 3 cycles -> mem_req_valid, mem_addr, mem_be and mem_wdata stable all 3 cycles, stall=1; mem_resp_valid pulsed during REQ is ignored.
REQ-042 LW accepted, reset asserted in RESP, then a response arrives -> all outputs 0 immediately, no ld_valid after reset release.
